// File: rtl/llbitcoin_pkg.sv
// llbitcoin_pkg: state encoding, input-handler command codes and header geometry shared across the loader datapath
package llbitcoin_pkg;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_GAP       = 3'd2,
        S_LAUNCH    = 3'd3,
        S_WAIT_CORE = 3'd4,
        S_ERROR     = 3'd5
    } state_t;
    localparam logic [7:0] CMD_NOP    = 8'h0;
    localparam logic [7:0] CMD_LOAD   = 8'h1;
    localparam logic [7:0] CMD_STATUS = 8'h2;
    localparam logic [7:0] CMD_ABORT  = 8'h3;
    localparam int WORDS_PER_HEADER = 20;
endpackage

// File: rtl/req_timeout_counter.sv
// req_timeout_counter: reloadable down-counter watchdog; expired flags that the reload period has fully elapsed
module req_timeout_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);
    logic [WIDTH-1:0] count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= load_value;
        else if (count_en && count != '0)
            count <= count - 1'b1;
    end
    assign expired = count == '0;
endmodule

// File: rtl/header_load_sequencer.sv
// header_load_sequencer: pulls header words from the input handler into core memory, launches the core, repeats while enabled
module header_load_sequencer
    import llbitcoin_pkg::*;
#(
    parameter int         WORDS     = WORDS_PER_HEADER,
    parameter int         ADDR_W    = 5,
    parameter int         TIMEOUT   = 1024,
    parameter logic [7:0] CMD_ABORT = llbitcoin_pkg::CMD_ABORT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        command,
    input  logic [31:0]       buffer,
    input  logic              ready,
    output logic              data_request,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              core_busy,
    input  logic              core_done,
    output logic              core_start,
    output logic              busy,
    output logic              error,
    output logic [15:0]       job_count,
    output logic [2:0]        state_dbg
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    state_t state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic expired, req_ready, abort, write;
    assign req_ready = state == S_REQ && enable && ready;
    assign abort     = req_ready && command == CMD_ABORT;
    assign write     = req_ready && !abort;
    assign state_dbg = state;
    // Reloads outside REQ, so every new request starts a full timeout window
    req_timeout_counter #(.WIDTH(TW)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear     (state != S_REQ),
        .count_en  (state == S_REQ),
        .load_value(TW'(TIMEOUT - 1)),
        .expired   (expired)
    );
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_REQ;
                    idx_n   = '0;
                end
            end
            S_REQ: begin
                if (!enable)
                    state_n = S_IDLE;
                else if (abort) begin
                    state_n = S_GAP;
                    idx_n   = '0;
                end else if (write) begin
                    state_n = idx == ADDR_W'(WORDS - 1) ? S_LAUNCH : S_GAP;
                    idx_n   = idx + 1'b1;
                end else if (expired)
                    state_n = S_ERROR;
            end
            S_GAP:       state_n = enable ? S_REQ : S_IDLE;
            S_LAUNCH:    state_n = core_busy ? S_LAUNCH : S_WAIT_CORE;
            S_WAIT_CORE: begin
                if (core_done) begin
                    state_n = enable ? S_GAP : S_IDLE;
                    idx_n   = '0;
                end
            end
            S_ERROR:     state_n = enable ? S_ERROR : S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end
    // Status outputs are registered from the next state so they line up with state_dbg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            data_request <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_start   <= 1'b0;
            job_count    <= '0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            data_request <= state_n == S_REQ;
            busy         <= state_n != S_IDLE;
            error        <= state_n == S_ERROR;
            mem_we       <= write;
            if (write) begin
                mem_addr  <= idx;
                mem_wdata <= buffer;
            end
            core_start <= state == S_LAUNCH && !core_busy;
            if (state == S_WAIT_CORE && core_done)
                job_count <= job_count + 1'b1;
        end
    end
endmodule
